mem_dma: RTL
============

# mem_dma

Bus-master block-transfer engine for the single-port synchronous RAM bus (cs / rw / addr / data, registered read data). It drives the initiator side of that bus and either copies a block of words from one RAM region to another or fills a region with a constant. It sits between the control logic and the RAM, and keeps the bus idle whenever it is not transferring.

## Interface
Parameters:
- A, 10, address width; regions wrap modulo 2^A.
- D, 8, data word width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; forces the idle state immediately.
- start  in  1  request; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill.
- src_addr  in  A  copy source base address.
- dst_addr  in  A  destination base address.
- len  in  A  number of words to transfer; 0 means a null transfer.
- fill_value  in  D  word written in fill mode.
- busy  out  1  high in every non-IDLE state.
- done  out  1  single-cycle completion pulse.
- mem_cs  out  1  RAM chip select.
- mem_rw  out  1  1 = read, 0 = write.
- mem_addr  out  A  RAM address.
- mem_wdata  out  D  write data, connects to RAM data_in.
- mem_rdata  in  D  read data from RAM data_out; valid one cycle after the read cycle.

## Operation
- States are IDLE, RD, RWAIT, WR and DONE.
- IDLE: when start=1 at a posedge, the block latches mode, src_addr, dst_addr, len and fill_value, clears idx, and moves to:
  - DONE if len=0;
  - WR if mode=1;
  - RD if mode=0.
- RD: mem_cs=1, mem_rw=1, mem_addr=src+idx. The next state is RWAIT.
- RWAIT: mem_cs=0. At the end of the cycle the block captures mem_rdata into its data register. The next state is WR.
- WR: mem_cs=1, mem_rw=0, mem_addr=dst+idx. mem_wdata is the data register in copy mode and the latched fill_value in fill mode.
  - At the end of the cycle idx increments.
  - If idx+1 == len, the next state is DONE.
  - Otherwise the next state is RD (copy) or WR (fill).
- DONE: done=1 and mem_cs=0. The next state is IDLE.
- Address arithmetic is A-bit and wraps silently, e.g. 0x3FF+1 gives 0x000.
- Overlapping regions use a forward copy in ascending idx order. The result is defined by that order: with dst > src, source words are overwritten before they are read.
- start is ignored while busy. Input changes after the start edge have no effect.
- Bus outputs are decoded only from registered state and latched operands; there is no combinational path from any input to them.
- Outside RD/WR: mem_cs=0, mem_rw=1, mem_addr=0, mem_wdata=0.

## Timing
- Reset values: state=IDLE, busy=0, done=0, mem_cs=0, mem_rw=1, mem_addr=0, mem_wdata=0, idx=0, data register=0.
- Reset asserted mid-transfer aborts the transfer:
  - mem_cs drops asynchronously;
  - no done pulse is issued;
  - words already written stay written.
- Copy takes 3 cycles per word. Fill takes 1 cycle per word.
- With the start edge as cycle 0:
  - done is high in cycle 3N+1 (copy) or N+1 (fill);
  - done is high in cycle 1 when len=0.
- busy rises in cycle 1 and falls after the DONE cycle.
- The earliest next start is accepted at the edge that ends the first IDLE cycle following DONE.
- Read contract: the RAM samples RD at the edge ending RD and drives mem_rdata during RWAIT. The RAM must not change data_out while cs=0.

## Structure
- Package mem_dma_pkg holds:
  - the state enum (IDLE, RD, RWAIT, WR, DONE);
  - constants MODE_COPY=1'b0 and MODE_FILL=1'b1;
  - RW_READ=1'b1 and RW_WRITE=1'b0.
- The block is a single module with no sub-module.
- The testbench instantiates the existing ram (A=10, D=8) as the bus target.

## Test plan
- Fill, dst=0x010, len=4, fill_value=0xA5 -> mem[0x010..0x013]=0xA5, mem[0x014] unchanged, done in cycle 5.
- Copy, src=0x000 (preloaded 0x11, 0x22, 0x33), dst=0x100, len=3 -> mem[0x100..0x102]=0x11, 0x22, 0x33, done in cycle 10, exactly three mem_cs read cycles.
- Wrap: fill with dst=0x3FE, len=3, 0x5A -> mem[0x3FE], mem[0x3FF] and mem[0x000] equal 0x5A.
- len=0 with start -> no mem_cs activity, done in cycle 1; a second start pulse while busy during a len=8 fill is ignored, giving exactly one done.
- Overlap: copy src=0x020 holding 1, 2, 3, 4, dst=0x021, len=3 -> mem[0x021..0x023]=1, 1, 1.
- Reset asserted during the second word of a len=4 copy -> mem_cs=0 immediately, busy=0, no done, only word 0 written. A new start afterwards completes normally.

Source files
------------

// File: rtl/mem_dma_pkg.sv
// Shared types and bus encodings for the mem_dma block-transfer engine.
package mem_dma_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RWAIT,
      WR,
      DONE
   } state_t;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;
   localparam logic RW_READ   = 1'b1;
   localparam logic RW_WRITE  = 1'b0;

endpackage

// File: rtl/mem_dma.sv
// Bus-master engine that copies or fills a block of words on the single-port
// synchronous RAM bus, leaving the bus idle whenever no transfer is running.
module mem_dma
   import mem_dma_pkg::*;
#(
   parameter int A = 10,
   parameter int D = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         mode,
   input  logic [A-1:0] src_addr,
   input  logic [A-1:0] dst_addr,
   input  logic [A-1:0] len,
   input  logic [D-1:0] fill_value,
   output logic         busy,
   output logic         done,
   output logic         mem_cs,
   output logic         mem_rw,
   output logic [A-1:0] mem_addr,
   output logic [D-1:0] mem_wdata,
   input  logic [D-1:0] mem_rdata
);

   localparam logic [A-1:0] ONE = {{(A-1){1'b0}}, 1'b1};

   state_t       r_state;
   state_t       w_next;
   logic         r_mode;
   logic [A-1:0] r_src;
   logic [A-1:0] r_dst;
   logic [A-1:0] r_len;
   logic [D-1:0] r_fill;
   logic [A-1:0] r_idx;
   logic [D-1:0] r_data;
   logic [A-1:0] w_idx_inc;

   assign w_idx_inc = r_idx + ONE;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Operands are frozen at the start edge so later input changes cannot disturb a transfer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode <= MODE_COPY;
         r_src  <= '0;
         r_dst  <= '0;
         r_len  <= '0;
         r_fill <= '0;
         r_idx  <= '0;
         r_data <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mode <= mode;
                  r_src  <= src_addr;
                  r_dst  <= dst_addr;
                  r_len  <= len;
                  r_fill <= fill_value;
                  r_idx  <= '0;
               end
            end
            RWAIT:   r_data <= mem_rdata;
            WR:      r_idx  <= w_idx_inc;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (len == '0) begin
                  w_next = DONE;
               end else if (mode == MODE_FILL) begin
                  w_next = WR;
               end else begin
                  w_next = RD;
               end
            end
         end
         RD:    w_next = RWAIT;
         RWAIT: w_next = WR;
         WR: begin
            if (w_idx_inc == r_len) begin
               w_next = DONE;
            end else if (r_mode == MODE_FILL) begin
               w_next = WR;
            end else begin
               w_next = RD;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Bus outputs depend only on registered state and latched operands.
   always_comb begin
      busy      = (r_state != IDLE);
      done      = 1'b0;
      mem_cs    = 1'b0;
      mem_rw    = RW_READ;
      mem_addr  = '0;
      mem_wdata = '0;
      case (r_state)
         RD: begin
            mem_cs   = 1'b1;
            mem_addr = r_src + r_idx;
         end
         WR: begin
            mem_cs    = 1'b1;
            mem_rw    = RW_WRITE;
            mem_addr  = r_dst + r_idx;
            mem_wdata = (r_mode == MODE_FILL) ? r_fill : r_data;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

endmodule
